// File: rtl/flag_unit.sv
`default_nettype none
//==============================================================================
// Module      : flag_unit
// Description : Registered NZCV flag unit. Computes flags for CMP/CMN/TST/TEQ
//               at any operand width, holds them in an architectural flags
//               register with restore support, and evaluates a 4-bit ARM
//               condition code against the committed flags.
// Revision    : 1.0 - initial release
//==============================================================================
module flag_unit #(
    parameter int         WIDTH       = 32,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             flags_we,
    input  logic [3:0]       flags_wdata,
    input  logic [3:0]       cond,
    output logic [3:0]       nzcv,
    output logic             out_valid,
    output logic             cond_pass
);

    // Operand MSB index, shared by the sign and overflow logic.
    localparam int c_MSB = WIDTH - 1;

    // Operation encodings.
    localparam logic [1:0] c_OP_CMP = 2'b00;
    localparam logic [1:0] c_OP_CMN = 2'b01;
    localparam logic [1:0] c_OP_TST = 2'b10;
    localparam logic [1:0] c_OP_TEQ = 2'b11;

    // Condition code encodings (ARM order).
    localparam logic [3:0] c_COND_EQ = 4'h0;
    localparam logic [3:0] c_COND_NE = 4'h1;
    localparam logic [3:0] c_COND_CS = 4'h2;
    localparam logic [3:0] c_COND_CC = 4'h3;
    localparam logic [3:0] c_COND_MI = 4'h4;
    localparam logic [3:0] c_COND_PL = 4'h5;
    localparam logic [3:0] c_COND_VS = 4'h6;
    localparam logic [3:0] c_COND_VC = 4'h7;
    localparam logic [3:0] c_COND_HI = 4'h8;
    localparam logic [3:0] c_COND_LS = 4'h9;
    localparam logic [3:0] c_COND_GE = 4'hA;
    localparam logic [3:0] c_COND_LT = 4'hB;
    localparam logic [3:0] c_COND_GT = 4'hC;
    localparam logic [3:0] c_COND_LE = 4'hD;
    localparam logic [3:0] c_COND_AL = 4'hE;
    localparam logic [3:0] c_COND_NV = 4'hF;

    // Gated operands: idle-cycle inputs (possibly X) never reach the datapath.
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [1:0]       w_op;

    // One-bit-wider arithmetic so the carry/borrow is a plain result bit.
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_sum;

    // Per-operation result and flags.
    logic [WIDTH-1:0] w_result;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_op_flags;
    logic [3:0]       w_nzcv_next;

    // Architectural state.
    logic [3:0]       r_nzcv;
    logic             r_out_valid;

    // Block operands and opcode while no operation is requested.
    always_comb begin
        w_a  = in_valid ? val1 : '0;
        w_b  = in_valid ? val2 : '0;
        w_op = in_valid ? op   : c_OP_CMP;
    end

    assign w_diff = {1'b0, w_a} - {1'b0, w_b};
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};

    // Select the result and the C/V rules of the requested operation.
    always_comb begin
        w_result = w_diff[c_MSB:0];
        w_c      = r_nzcv[1];
        w_v      = r_nzcv[0];
        case (w_op)
            c_OP_CMP: begin
                w_result = w_diff[c_MSB:0];
                // No borrow out of the MSB means val1 >= val2 unsigned.
                w_c      = ~w_diff[WIDTH];
                w_v      = (w_a[c_MSB] != w_b[c_MSB]) &
                           (w_diff[c_MSB] != w_a[c_MSB]);
            end
            c_OP_CMN: begin
                w_result = w_sum[c_MSB:0];
                w_c      = w_sum[WIDTH];
                w_v      = (w_a[c_MSB] == w_b[c_MSB]) &
                           (w_sum[c_MSB] != w_a[c_MSB]);
            end
            c_OP_TST: begin
                // Logical ops leave C and V at their committed values.
                w_result = w_a & w_b;
            end
            c_OP_TEQ: begin
                w_result = w_a ^ w_b;
            end
            default: begin
                w_result = w_diff[c_MSB:0];
            end
        endcase
        w_n = w_result[c_MSB];
        w_z = ~|w_result;
    end

    assign w_op_flags = {w_n, w_z, w_c, w_v};

    // Restore beats a computed update; a simultaneous op's flags are dropped.
    always_comb begin
        w_nzcv_next = r_nzcv;
        if (flags_we) begin
            w_nzcv_next = flags_wdata;
        end else if (in_valid) begin
            w_nzcv_next = w_op_flags;
        end
    end

    // Flags register and completion pulse, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nzcv      <= RESET_FLAGS;
            r_out_valid <= 1'b0;
        end else begin
            r_nzcv      <= w_nzcv_next;
            r_out_valid <= in_valid;
        end
    end

    // Condition evaluation uses the committed flags only, with no bypass.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            c_COND_EQ: cond_pass =  r_nzcv[2];
            c_COND_NE: cond_pass = ~r_nzcv[2];
            c_COND_CS: cond_pass =  r_nzcv[1];
            c_COND_CC: cond_pass = ~r_nzcv[1];
            c_COND_MI: cond_pass =  r_nzcv[3];
            c_COND_PL: cond_pass = ~r_nzcv[3];
            c_COND_VS: cond_pass =  r_nzcv[0];
            c_COND_VC: cond_pass = ~r_nzcv[0];
            c_COND_HI: cond_pass =  r_nzcv[1] & ~r_nzcv[2];
            c_COND_LS: cond_pass = ~r_nzcv[1] |  r_nzcv[2];
            c_COND_GE: cond_pass =  (r_nzcv[3] == r_nzcv[0]);
            c_COND_LT: cond_pass =  (r_nzcv[3] != r_nzcv[0]);
            c_COND_GT: cond_pass = ~r_nzcv[2] &  (r_nzcv[3] == r_nzcv[0]);
            c_COND_LE: cond_pass =  r_nzcv[2] |  (r_nzcv[3] != r_nzcv[0]);
            c_COND_AL: cond_pass = 1'b1;
            c_COND_NV: cond_pass = 1'b0;
            default:   cond_pass = 1'b0;
        endcase
    end

    assign nzcv      = r_nzcv;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_flag_unit
// Description : Self-checking bench for flag_unit. Drives a 32-bit and an
//               8-bit instance in lockstep and compares both against an
//               arithmetic reference model of the flag and condition rules.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_flag_unit;

    localparam logic [3:0] c_RST32 = 4'h0;
    localparam logic [3:0] c_RST8  = 4'hA;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [7:0]  val1_8;
    logic [7:0]  val2_8;
    logic        flags_we;
    logic [3:0]  flags_wdata;
    logic [3:0]  cond;
    logic [3:0]  nzcv32;
    logic [3:0]  nzcv8;
    logic        out_valid32;
    logic        out_valid8;
    logic        cond_pass32;
    logic        cond_pass8;

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp32;
    logic [3:0]  exp8;
    logic [31:0] corners [4];

    assign val1_8 = val1[7:0];
    assign val2_8 = val2[7:0];

    flag_unit #(.WIDTH(32), .RESET_FLAGS(c_RST32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op),
        .val1(val1), .val2(val2), .flags_we(flags_we),
        .flags_wdata(flags_wdata), .cond(cond), .nzcv(nzcv32),
        .out_valid(out_valid32), .cond_pass(cond_pass32)
    );

    flag_unit #(.WIDTH(8), .RESET_FLAGS(c_RST8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op),
        .val1(val1_8), .val2(val2_8), .flags_we(flags_we),
        .flags_wdata(flags_wdata), .cond(cond), .nzcv(nzcv8),
        .out_valid(out_valid8), .cond_pass(cond_pass8)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Reference flags from integer arithmetic on w-bit operands.
    function automatic logic [3:0] ref_flags(input int w, input logic [1:0] o,
                                             input logic [31:0] a_in, input logic [31:0] b_in,
                                             input logic [3:0] prev);
        logic [63:0] mask, a, b, full, r;
        longint      sa, sb, sr, smax, smin;
        logic        n, z, c, v;
        mask = (64'd1 << w) - 64'd1;
        a    = {32'd0, a_in} & mask;
        b    = {32'd0, b_in} & mask;
        smax = (longint'(1) <<< (w - 1)) - 1;
        smin = -smax - 1;
        sa   = (a > smax) ? $signed(a) - $signed(mask) - 1 : $signed(a);
        sb   = (b > smax) ? $signed(b) - $signed(mask) - 1 : $signed(b);
        c    = prev[1];
        v    = prev[0];
        r    = 64'd0;
        full = 64'd0;
        sr   = 0;
        case (o)
            2'b00: begin
                r  = (a - b) & mask;
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr > smax) || (sr < smin);
            end
            2'b01: begin
                full = a + b;
                r    = full & mask;
                c    = (full > mask);
                sr   = sa + sb;
                v    = (sr > smax) || (sr < smin);
            end
            2'b10:   r = a & b;
            default: r = a ^ b;
        endcase
        n = ((r >> (w - 1)) & 64'd1) == 64'd1;
        z = (r == 64'd0);
        return {n, z, c, v};
    endfunction

    // Condition codes come in true/inverted pairs; E/F form the AL/NV pair.
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: cond_pass is checked before the edge against the
    // old flags, then flags, out_valid and cond_pass after the edge.
    task automatic step(input logic iv, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic we, input logic [3:0] wd,
                        input logic [3:0] cc);
        logic [3:0] n32, n8;
        in_valid    = iv;
        op          = o;
        val1        = a;
        val2        = b;
        flags_we    = we;
        flags_wdata = wd;
        cond        = cc;
        #1;
        chk("pre_cond32", {3'b0, cond_pass32}, {3'b0, ref_cond(cc, exp32)});
        chk("pre_cond8",  {3'b0, cond_pass8},  {3'b0, ref_cond(cc, exp8)});
        n32 = exp32;
        n8  = exp8;
        if (we) begin
            n32 = wd;
            n8  = wd;
        end else if (iv) begin
            n32 = ref_flags(32, o, a, b, exp32);
            n8  = ref_flags(8, o, a, b, exp8);
        end
        @(posedge clk);
        exp32 = n32;
        exp8  = n8;
        #1;
        chk("nzcv32",      nzcv32,                exp32);
        chk("nzcv8",       nzcv8,                 exp8);
        chk("out_valid32", {3'b0, out_valid32},   {3'b0, iv});
        chk("out_valid8",  {3'b0, out_valid8},    {3'b0, iv});
        chk("cond32",      {3'b0, cond_pass32},   {3'b0, ref_cond(cc, exp32)});
        chk("cond8",       {3'b0, cond_pass8},    {3'b0, ref_cond(cc, exp8)});
    endtask

    task automatic all_conds();
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #1;
            chk("sweep_cond32", {3'b0, cond_pass32}, {3'b0, ref_cond(4'(i), exp32)});
            chk("sweep_cond8",  {3'b0, cond_pass8},  {3'b0, ref_cond(4'(i), exp8)});
        end
    endtask

    initial begin
        logic        iv, we;
        logic [1:0]  o;
        logic [31:0] a, b;

        corners[0] = 32'h0000_0000;
        corners[1] = 32'h7fff_ffff;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'hffff_ffff;

        // Asynchronous reset before any clock edge.
        reset = 1'b1; in_valid = 1'b0; op = 2'b00; val1 = '0; val2 = '0;
        flags_we = 1'b0; flags_wdata = 4'h0; cond = 4'hE;
        exp32 = c_RST32;
        exp8  = c_RST8;
        #1;
        chk("reset_nzcv32", nzcv32, c_RST32);
        chk("reset_nzcv8",  nzcv8,  c_RST8);
        chk("reset_ov32",   {3'b0, out_valid32}, 4'h0);
        chk("reset_ov8",    {3'b0, out_valid8},  4'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // CMP corner sweep, back to back.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                step(1'b1, 2'b00, corners[i], corners[j], 1'b0, 4'h0, 4'(i * 4 + j));

        // CMN at 8 bits.
        step(1'b1, 2'b01, 32'h7f, 32'h01, 1'b0, 4'h0, 4'h6);
        chk("cmn8_7f_01", nzcv8, 4'h9);
        step(1'b1, 2'b01, 32'hff, 32'h01, 1'b0, 4'h0, 4'h0);
        chk("cmn8_ff_01", nzcv8, 4'h6);
        step(1'b1, 2'b01, 32'h80, 32'h80, 1'b0, 4'h0, 4'h6);
        chk("cmn8_80_80", nzcv8, 4'h7);

        // Logical ops keep C and V.
        step(1'b1, 2'b00, 32'h0, 32'h8000_0000, 1'b0, 4'h0, 4'hB);
        chk("cmp_0_8000", nzcv32, 4'h9);
        step(1'b1, 2'b10, 32'hffff_ffff, 32'h0, 1'b0, 4'h0, 4'h6);
        chk("tst_ff_00", nzcv32, 4'h5);
        step(1'b1, 2'b11, 32'h5, 32'h5, 1'b0, 4'h0, 4'h0);
        chk("teq_5_5", nzcv32, 4'h5);

        // Restores and full condition sweeps.
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 4'hA, 4'hA);
        all_conds();
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 4'h6, 4'h0);
        all_conds();
        cond = 4'h0; #1; chk("eq_after_6", {3'b0, cond_pass32}, 4'h1);
        cond = 4'h8; #1; chk("hi_after_6", {3'b0, cond_pass32}, 4'h0);
        cond = 4'h9; #1; chk("ls_after_6", {3'b0, cond_pass32}, 4'h1);
        cond = 4'h2; #1; chk("cs_after_6", {3'b0, cond_pass32}, 4'h1);
        cond = 4'hE; #1; chk("al_always",  {3'b0, cond_pass32}, 4'h1);
        cond = 4'hF; #1; chk("nv_never",   {3'b0, cond_pass32}, 4'h0);

        // Restore collides with an op: restore wins, op still completes.
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 4'hF, 4'h0);
        chk("simul_nzcv32", nzcv32, 4'hF);
        chk("simul_ov32",   {3'b0, out_valid32}, 4'h1);

        // Reset asserted mid-cycle with an op in flight.
        step(1'b1, 2'b00, 32'h5, 32'h3, 1'b0, 4'h0, 4'hE);
        in_valid = 1'b1; op = 2'b01; val1 = 32'h1234; val2 = 32'h4321;
        #20;
        reset = 1'b1;
        exp32 = c_RST32;
        exp8  = c_RST8;
        #1;
        chk("async_nzcv32", nzcv32, c_RST32);
        chk("async_nzcv8",  nzcv8,  c_RST8);
        chk("async_ov32",   {3'b0, out_valid32}, 4'h0);
        chk("async_ov8",    {3'b0, out_valid8},  4'h0);
        @(posedge clk);
        #1;
        chk("held_nzcv32", nzcv32, c_RST32);
        chk("held_ov32",   {3'b0, out_valid32}, 4'h0);
        reset = 1'b0;
        step(1'b1, 2'b00, 32'h10, 32'h20, 1'b0, 4'h0, 4'hB);

        // Randomized traffic; idle cycles drive X on op/operands.
        for (int k = 0; k < 300; k++) begin
            iv = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 7) == 0);
            if (iv) begin
                o = 2'($urandom_range(0, 3));
                a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
                b = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            end else begin
                o = 2'bxx;
                a = 32'hxxxx_xxxx;
                b = 32'hxxxx_xxxx;
            end
            step(iv, o, a, b, we, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
